// File: rtl/c432_irq_dispatch.sv
// Purpose: registers the c432 priority core outputs, glitch-filters them and offers one interrupt ID at a time.
// Latency: STABLE_CYCLES edges from the first sample of a constant request to irq_valid_o; all outputs registered.
// Backpressure: an issued ID is held until irq_ready_i (or dropped after TIMEOUT_CYCLES when C432_IRQ_DISP_TIMEOUT_EN is defined).
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   pa_i, pb_i, pc_i  bus A/B/C grant flags from the c432 core (priority A > B > C)
//   chan_i[3:0]       channel code from the core, MSB first
//   irq_valid_o       interrupt ID on offer
//   irq_id_o[5:0]     {bus[1:0], chan[3:0]}, bus A=00, B=01, C=10
//   irq_ready_i       consumer accepts (ignored outside the issue state)
//   busy_o            dispatcher not idle
//   timeout_err_o     sticky consumer-timeout flag (constant 0 unless C432_IRQ_DISP_TIMEOUT_EN)
//
// Optional feature macro: C432_IRQ_DISP_TIMEOUT_EN enables the consumer-ready timeout.

module c432_irq_dispatch #(
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pa_i,
    input  logic       pb_i,
    input  logic       pc_i,
    input  logic [3:0] chan_i,
    output logic       irq_valid_o,
    output logic [5:0] irq_id_o,
    input  logic       irq_ready_i,
    output logic       busy_o,
    output logic       timeout_err_o
);

    // cnt counts repeats after the first sample, so N identical samples give cnt = N-1.
    localparam logic [3:0] STABLE_THR = 4'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // Combinational view of the incoming core outputs.
    logic       smp_vld;
    logic [5:0] smp_id;

    // Registered sample and its stability counter.
    logic       s_vld;
    logic [5:0] s_id;
    logic [3:0] cnt;

    logic       req_stable;
    logic       timeout_hit;

    // ------------------------------------------------------------------
    // Input encoding: bus A wins over B, B over C; no grant means ID 0.
    // ------------------------------------------------------------------
    always_comb begin
        smp_vld = pa_i | pb_i | pc_i;
        smp_id  = 6'd0;
        if (pa_i) begin
            smp_id = {2'b00, chan_i};
        end else if (pb_i) begin
            smp_id = {2'b01, chan_i};
        end else if (pc_i) begin
            smp_id = {2'b10, chan_i};
        end
    end

    // ------------------------------------------------------------------
    // Sample register and stability counter. The valid bit is part of the
    // comparison because ID 0 (bus A, channel 0) is a legal request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_vld <= 1'b0;
            s_id  <= 6'd0;
            cnt   <= 4'd0;
        end else begin
            s_vld <= smp_vld;
            s_id  <= smp_id;
            if (!smp_vld || (smp_vld != s_vld) || (smp_id != s_id)) begin
                cnt <= 4'd0;
            end else if (cnt != 4'hF) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign req_stable = s_vld && (cnt >= STABLE_THR);

    // ------------------------------------------------------------------
    // Optional consumer timeout.
    // ------------------------------------------------------------------
`ifdef C432_IRQ_DISP_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       timeout_err;

    // wait_cnt = number of ISSUE edges already passed without a transfer;
    // the edge on which it equals WAIT_LAST is the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (state != ST_ISSUE) begin
                wait_cnt <= 8'd0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            // A transfer on the expiry edge takes precedence over the error.
            if (timeout_hit && !irq_ready_i) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_hit   = (state == ST_ISSUE) && (wait_cnt == WAIT_LAST);
    assign timeout_err_o = timeout_err;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_err_o      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ISSUE ignores the upstream request entirely; HOLDOFF releases only
    // once the registered request no longer matches the delivered ID.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_stable) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (irq_ready_i || timeout_hit) begin
                    state_nxt = ST_HOLDOFF;
                end
            end
            ST_HOLDOFF: begin
                if (!s_vld || (s_id != irq_id_o)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs, decoded from the state register only.
    // ------------------------------------------------------------------
    always_comb begin
        irq_valid_o = (state == ST_ISSUE);
        busy_o      = (state != ST_IDLE);
    end

    // Issued ID: captured on the IDLE->ISSUE edge, frozen afterwards. It is
    // also the reference HOLDOFF compares against to block re-issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_id_o <= 6'd0;
        end else if ((state == ST_IDLE) && req_stable) begin
            irq_id_o <= s_id;
        end
    end

endmodule

// File: doc/c432_irq_dispatch.md
# c432_irq_dispatch

Sequential dispatch stage that sits directly downstream of the combinational `c432` 27-channel priority interrupt core. It registers the core's bus-grant flags (`PA`/`PB`/`PC`, nets `223`/`329`/`370`) and its 4-bit channel code (`421`, `430`, `431`, `432`). It glitch-filters the registered result, then presents one interrupt ID at a time to a consumer over a valid/ready handshake. After delivery it blocks re-issue of the same request until that request changes or clears.

## Interface
Parameters:
- `STABLE_CYCLES`, default 2: number of consecutive identical samples required before issue. Legal range 1..15.
- `TIMEOUT_CYCLES`, default 64: consumer-ready timeout in cycles. Used only with `C432_IRQ_DISP_TIMEOUT_EN`; legal range 2..255.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pa_i`  in  1  bus A grant from core (net `223`).
- `pb_i`  in  1  bus B grant (net `329`).
- `pc_i`  in  1  bus C grant (net `370`).
- `chan_i`  in  4  channel code {`421`,`430`,`431`,`432`}, MSB first.
- `irq_valid_o`  out  1  ID available.
- `irq_id_o`  out  6  {bus[1:0], chan[3:0]}. Bus encoding: A=00, B=01, C=10.
- `irq_ready_i`  in  1  consumer accepts.
- `busy_o`  out  1  FSM not in IDLE.
- `timeout_err_o`  out  1  sticky timeout flag.

## Operation
- **Input stage**: on every edge, latch `s_vld = pa|pb|pc` and `s_id`.
  - Bus priority: A > B > C. If `pa_i`=1, bus=00 regardless of `pb_i`/`pc_i`.
  - `s_id` = 0 when `s_vld`=0.
- **Stability counter** `cnt` (4 bits):
  - Cleared when the new sample differs from the previous sample, or when `s_vld`=0.
  - Otherwise increments, saturating at 15.
  - The request is "stable" when `s_vld`=1 and `cnt` ≥ `STABLE_CYCLES`-1.
- **FSM states:**
  - IDLE → ISSUE when the request is stable. `irq_id_o` is loaded from `s_id` on the same edge.
  - ISSUE: `irq_valid_o`=1 and `irq_id_o` is frozen.
    - Changes, loss of the request, or reappearance of the request upstream are ignored; the issued ID is never retracted.
    - `irq_valid_o & irq_ready_i` at an edge → HOLDOFF.
  - HOLDOFF: `irq_valid_o`=0.
    - → IDLE at the first edge where `s_vld`=0 or `s_id` ≠ the issued ID.
    - `cnt` keeps running, so a new ID that is already stable passes through IDLE and then issues on the following edge.
- `irq_ready_i` outside ISSUE is ignored.
- `busy_o` = (state ≠ IDLE).
- **Asynchronous reset at any point, including mid-handshake:**
  - State → IDLE.
  - All registers → 0.
  - Any pending ID is discarded without delivery.

## Timing
- Reset values: `irq_valid_o`=0, `irq_id_o`=0, `busy_o`=0, `timeout_err_o`=0.
- Latency: with inputs constant before edge 0, edge 0 takes the first sample and `irq_valid_o` rises after edge `STABLE_CYCLES`.
  - `STABLE_CYCLES`=1 gives a 1-cycle latency.
- Handshake: transfer occurs at the edge where valid and ready are both high. `irq_valid_o` falls after that edge.
  - Back-to-back transfers of different IDs are spaced at least 3 cycles apart: ISSUE → HOLDOFF → IDLE → ISSUE.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- With `C432_IRQ_DISP_TIMEOUT_EN` defined:
  - An 8-bit wait counter runs while in ISSUE.
  - After `TIMEOUT_CYCLES` cycles in ISSUE without a transfer: FSM → HOLDOFF, the ID is dropped, and `timeout_err_o` is set.
  - `timeout_err_o` is sticky and cleared only by reset.
  - If ready arrives on the same edge as expiry, the transfer wins and `timeout_err_o` is not set.
- Without the macro:
  - There is no wait counter.
  - ISSUE waits indefinitely for ready.
  - `timeout_err_o` is tied to 0.

## Test plan
- **Reset**:
  - Stimulus: `rst_n`=0 with `pa_i`=1, `chan_i`=5.
  - Required: all outputs 0. After release with inputs held, `irq_valid_o` rises after edge 2, with `irq_id_o`=6'b00_0101.
- **Priority and glitch filter**:
  - Stimulus: `pb_i`=1, `chan_i`=3 for 1 cycle, then `pc_i`=1 (`pa_i`, `pb_i`=0), `chan_i`=9 held.
  - Required: no issue for the glitch; after the C request settles, the issued ID is 6'b10_1001. With `pa_i`=`pb_i`=1, the bus field is 00.
- **Hold-off**:
  - Stimulus: ID 0x07 accepted with `irq_ready_i`=1, request held constant for 20 cycles.
  - Required: `irq_valid_o` stays 0 and `busy_o`=1. After `chan_i` changes to 8, the new ID 0x08 issues 3 cycles after the change.
- **Frozen ID**:
  - Stimulus: during ISSUE with ready=0, the inputs change and then all grants drop.
  - Required: `irq_id_o` stays unchanged and `irq_valid_o` stays 1 until ready.
- **Mid-handshake reset**:
  - Stimulus: assert `rst_n`=0 asynchronously while valid=1.
  - Required: valid clears immediately, without waiting for a clock edge.
- **Timeout** (with macro, `TIMEOUT_CYCLES`=4):
  - Stimulus: ready held 0.
  - Required: after 4 cycles in ISSUE, `irq_valid_o`=0 and `timeout_err_o`=1, and the flag stays set.
  - Stimulus: ready asserted on the expiry edge.
  - Required: transfer completes and the flag is not set.
